// File: rtl/bt_target_pipe.sv
// Branch-target unit for the EX stage: operand select, add, JALR clear,
// link and misalignment, followed by a 2-entry valid/ready skid buffer.

package bt_target_pipe_pkg;
  typedef enum logic [1:0] {
    OP_A_REG_A  = 2'd0,
    OP_A_CURRPC = 2'd1
  } op_a_sel_e;

  typedef enum logic [2:0] {
    IMM_B_I       = 3'd0,
    IMM_B_B       = 3'd1,
    IMM_B_J       = 3'd2,
    IMM_B_INCR_PC = 3'd3
  } imm_b_sel_e;
endpackage

module bt_target_pipe
  import bt_target_pipe_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter bit          HAS_C = 1'b1,
  parameter int unsigned TAG_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        in_a_sel_i,
  input  logic [2:0]        in_b_sel_i,
  input  logic [XLEN-1:0]   in_rs1_i,
  input  logic [XLEN-1:0]   in_pc_i,
  input  logic [XLEN-1:0]   in_imm_i_i,
  input  logic [XLEN-1:0]   in_imm_b_i,
  input  logic [XLEN-1:0]   in_imm_j_i,
  input  logic              in_compressed_i,
  input  logic [TAG_W-1:0]  in_tag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   out_target_o,
  output logic [XLEN-1:0]   out_link_o,
  output logic              out_misaligned_o,
  output logic [TAG_W-1:0]  out_tag_o
);

  logic              sel_reg_a_c;
  logic              is_jalr_c;
  logic [XLEN-1:0]   incr_c;
  logic [XLEN-1:0]   op_a_c;
  logic [XLEN-1:0]   op_b_c;
  logic [XLEN-1:0]   sum_c;
  logic [XLEN-1:0]   target_c;
  logic [XLEN-1:0]   link_c;
  logic              mis_c;

  logic              accept_c;
  logic              drain_c;

  logic [XLEN-1:0]   main_target_q, main_target_n;
  logic [XLEN-1:0]   main_link_q,   main_link_n;
  logic              main_mis_q,    main_mis_n;
  logic [TAG_W-1:0]  main_tag_q,    main_tag_n;
  logic              main_valid_q,  main_valid_n;

  logic [XLEN-1:0]   skid_target_q, skid_target_n;
  logic [XLEN-1:0]   skid_link_q,   skid_link_n;
  logic              skid_mis_q,    skid_mis_n;
  logic [TAG_W-1:0]  skid_tag_q,    skid_tag_n;
  logic              skid_valid_q,  skid_valid_n;

  logic              ready_q,       ready_n;

  // Target datapath: operand selection, wrapping add, JALR clear and alignment.
  always_comb begin
    sel_reg_a_c = (in_a_sel_i == 2'(OP_A_REG_A));
    is_jalr_c   = sel_reg_a_c && (in_b_sel_i == 3'(IMM_B_I));
    incr_c      = (HAS_C && in_compressed_i) ? XLEN'(2) : XLEN'(4);
    op_a_c      = sel_reg_a_c ? in_rs1_i : in_pc_i;
    case (in_b_sel_i)
      3'(IMM_B_I): op_b_c = in_imm_i_i;
      3'(IMM_B_B): op_b_c = in_imm_b_i;
      3'(IMM_B_J): op_b_c = in_imm_j_i;
      default:     op_b_c = incr_c;
    endcase
    sum_c    = op_a_c + op_b_c;
    target_c = {sum_c[XLEN-1:1], sum_c[0] & ~is_jalr_c};
    link_c   = in_pc_i + incr_c;
    mis_c    = HAS_C ? target_c[0] : (target_c[1] | target_c[0]);
  end

  assign accept_c = in_valid_i && ready_q && !flush_i;
  assign drain_c  = main_valid_q && out_ready_i;

  // Skid-buffer next state; skid valid implies main valid, so a skid->main
  // move never coincides with an accept (ready is low while skid is full).
  always_comb begin
    main_target_n = main_target_q;
    main_link_n   = main_link_q;
    main_mis_n    = main_mis_q;
    main_tag_n    = main_tag_q;
    main_valid_n  = main_valid_q;
    skid_target_n = skid_target_q;
    skid_link_n   = skid_link_q;
    skid_mis_n    = skid_mis_q;
    skid_tag_n    = skid_tag_q;
    skid_valid_n  = skid_valid_q;

    if (flush_i) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
    end else if (drain_c && skid_valid_q) begin
      main_target_n = skid_target_q;
      main_link_n   = skid_link_q;
      main_mis_n    = skid_mis_q;
      main_tag_n    = skid_tag_q;
      main_valid_n  = 1'b1;
      skid_valid_n  = 1'b0;
    end else begin
      if (drain_c) begin
        main_valid_n = 1'b0;
      end
      if (accept_c) begin
        if (!main_valid_q || drain_c) begin
          main_target_n = target_c;
          main_link_n   = link_c;
          main_mis_n    = mis_c;
          main_tag_n    = in_tag_i;
          main_valid_n  = 1'b1;
        end else begin
          skid_target_n = target_c;
          skid_link_n   = link_c;
          skid_mis_n    = mis_c;
          skid_tag_n    = in_tag_i;
          skid_valid_n  = 1'b1;
        end
      end
    end

    ready_n = !skid_valid_n;
  end

  // Storage registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_target_q <= '0;
      main_link_q   <= '0;
      main_mis_q    <= 1'b0;
      main_tag_q    <= '0;
      main_valid_q  <= 1'b0;
      skid_target_q <= '0;
      skid_link_q   <= '0;
      skid_mis_q    <= 1'b0;
      skid_tag_q    <= '0;
      skid_valid_q  <= 1'b0;
      ready_q       <= 1'b1;
    end else begin
      main_target_q <= main_target_n;
      main_link_q   <= main_link_n;
      main_mis_q    <= main_mis_n;
      main_tag_q    <= main_tag_n;
      main_valid_q  <= main_valid_n;
      skid_target_q <= skid_target_n;
      skid_link_q   <= skid_link_n;
      skid_mis_q    <= skid_mis_n;
      skid_tag_q    <= skid_tag_n;
      skid_valid_q  <= skid_valid_n;
      ready_q       <= ready_n;
    end
  end

  assign in_ready_o       = ready_q;
  assign out_valid_o      = main_valid_q;
  assign out_target_o     = main_target_q;
  assign out_link_o       = main_link_q;
  assign out_misaligned_o = main_mis_q;
  assign out_tag_o        = main_tag_q;

endmodule
